// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module      : led_seq_pkg
// Description : Shared mode encoding for the LED sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        STATIC = 2'b00,
        BLINK  = 2'b01,
        ROTATE = 2'b10,
        BOUNCE = 2'b11
    } mode_e;

endpackage

`default_nettype wire

// File: rtl/led_seq_prescaler.sv
// ============================================================================
// Module      : led_seq_prescaler
// Description : Free-running 0..PRESCALE-1 counter with a wrap pulse; clr
//               restarts the count and masks the pulse in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_seq_prescaler #(
    parameter int PRESCALE = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int c_CNT_W = $clog2(PRESCALE);

    logic [c_CNT_W-1:0] r_cnt;
    logic               w_at_top;

    assign w_at_top = (r_cnt == c_CNT_W'(PRESCALE - 1));
    assign tick     = w_at_top & ~clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || w_at_top) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// ============================================================================
// Module      : led_sequencer
// Description : LED pattern sequencer (static / blink / rotate / bounce).
//               Define LED_SEQ_PWM_EN to add duty-cycle brightness gating.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS   = 5,
    parameter int PRESCALE = 12000000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MODE_W-1:0]   mode,
    input  logic [N_LEDS-1:0]   pattern,
    input  logic [PWM_BITS-1:0] duty,
    output logic [N_LEDS-1:0]   led,
    output logic                tick
);

    localparam logic [N_LEDS-1:0] c_ONE = N_LEDS'(1);

    mode_e               r_mode_q;
    logic                r_phase;
    logic                r_dir_up;
    logic [N_LEDS-1:0]   r_shift;
    logic [N_LEDS-1:0]   r_led;

    mode_e               w_mode;
    logic                w_mode_chg;
    logic                w_tick;
    logic                w_phase_nxt;
    logic                w_dir_up_nxt;
    logic [N_LEDS-1:0]   w_shift_nxt;
    logic [N_LEDS-1:0]   w_mode_out;
    logic                w_pwm_on;

    function automatic logic [N_LEDS-1:0] rotl1(input logic [N_LEDS-1:0] x);
        return (x << 1) | (x >> (N_LEDS - 1));
    endfunction

    assign w_mode     = mode_e'(mode);
    assign w_mode_chg = (w_mode != r_mode_q);
    assign tick       = w_tick;
    assign led        = r_led;

    led_seq_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_mode_chg),
        .tick (w_tick)
    );

    always_comb begin
        w_phase_nxt  = r_phase;
        w_dir_up_nxt = r_dir_up;
        w_shift_nxt  = r_shift;
        if (w_mode_chg) begin
            w_phase_nxt  = 1'b1;
            w_dir_up_nxt = 1'b1;
            w_shift_nxt  = (w_mode == BOUNCE) ? c_ONE : pattern;
        end else if (w_tick) begin
            w_phase_nxt = ~r_phase;
            case (r_mode_q)
                ROTATE: w_shift_nxt = rotl1(r_shift);
                BOUNCE: begin
                    // Reverse on the same tick that reaches an end: no dwell.
                    if (N_LEDS > 1) begin
                        if (r_dir_up) begin
                            if (r_shift[N_LEDS-1]) begin
                                w_dir_up_nxt = 1'b0;
                                w_shift_nxt  = r_shift >> 1;
                            end else begin
                                w_shift_nxt  = r_shift << 1;
                            end
                        end else begin
                            if (r_shift[0]) begin
                                w_dir_up_nxt = 1'b1;
                                w_shift_nxt  = r_shift << 1;
                            end else begin
                                w_shift_nxt  = r_shift >> 1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_mode_out = '0;
        case (w_mode)
            STATIC:  w_mode_out = pattern;
            BLINK:   w_mode_out = w_phase_nxt ? pattern : '0;
            default: w_mode_out = w_shift_nxt;
        endcase
    end

`ifdef LED_SEQ_PWM_EN
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] w_pwm_nxt;

    assign w_pwm_nxt = r_pwm_cnt + PWM_BITS'(1);
    assign w_pwm_on  = (w_pwm_nxt < duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= w_pwm_nxt;
        end
    end
`else
    logic w_unused_duty;

    assign w_unused_duty = ^duty;
    assign w_pwm_on      = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q <= STATIC;
            r_phase  <= 1'b0;
            r_dir_up <= 1'b1;
            r_shift  <= '0;
            r_led    <= '0;
        end else begin
            r_mode_q <= w_mode;
            r_phase  <= w_phase_nxt;
            r_dir_up <= w_dir_up_nxt;
            r_shift  <= w_shift_nxt;
            r_led    <= w_mode_out & {N_LEDS{w_pwm_on}};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// Module      : tb_led_sequencer
// Description : Self-checking bench for led_sequencer (N_LEDS=5, PRESCALE=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_sequencer;

    localparam int N  = 5;
    localparam int PS = 4;
    localparam int PB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [N-1:0]  pattern;
    logic [PB-1:0] duty;
    logic [N-1:0]  led;
    logic          tick;

    int total = 0;
    int bad   = 0;

    // Reference state: ticks seen since the last mode change, and the pattern
    // captured at that change. LED values are derived arithmetically from these.
    logic [1:0]    m_mode_q;
    int            m_cnt;
    int            m_k;
    int            m_edges;
    logic [N-1:0]  m_saved;

    always #5 clk = ~clk;

    led_sequencer #(
        .N_LEDS   (N),
        .PRESCALE (PS),
        .PWM_BITS (PB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .pattern (pattern),
        .duty    (duty),
        .led     (led),
        .tick    (tick)
    );

    function automatic logic [N-1:0] model_led(input logic [1:0] md, input logic [N-1:0] pat);
        logic [N-1:0] r;
        int per;
        int pos;
        r = '0;
        case (md)
            2'd0: r = pat;
            2'd1: r = (m_k % 2 == 0) ? pat : '0;
            2'd2: for (int i = 0; i < N; i++) r[(i + m_k) % N] = m_saved[i];
            default: begin
                per = 2 * (N - 1);
                pos = (per == 0) ? 0 : (m_k % per);
                if (pos >= N) pos = per - pos;
                r[pos] = 1'b1;
            end
        endcase
`ifdef LED_SEQ_PWM_EN
        if (!((m_edges % (1 << PB)) < int'(duty))) r = '0;
`endif
        return r;
    endfunction

    function automatic void model_reset();
        m_mode_q = 2'd0;
        m_cnt    = 0;
        m_k      = 0;
        m_edges  = 0;
        m_saved  = '0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic [1:0] md, input logic [N-1:0] pat,
                         input logic [PB-1:0] dty, input string tag);
        logic chg;
        logic exp_tick;
        mode    = md;
        pattern = pat;
        duty    = dty;
        #1;
        chg      = (md != m_mode_q);
        exp_tick = !chg && (m_cnt == PS - 1);
        check({tag, "_tick"}, 32'(tick), 32'(exp_tick));
        @(posedge clk);
        #1;
        if (chg) begin
            m_cnt   = 0;
            m_k     = 0;
            m_saved = pat;
        end else begin
            if (exp_tick) m_k++;
            m_cnt = (m_cnt + 1) % PS;
        end
        m_mode_q = md;
        m_edges++;
        check({tag, "_led"}, 32'(led), 32'(model_led(md, pat)));
        @(negedge clk);
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_async_led"}, 32'(led), 32'd0);
        check({tag, "_async_tick"}, 32'(tick), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0]   md;
        logic [N-1:0] pat;
        int           hold;

        rst     = 1'b1;
        mode    = 2'd0;
        pattern = '0;
        duty    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        rst = 1'b0;

        repeat (12) cycle(2'd0, 5'b10101, 4'd15, "static");
        repeat (20) cycle(2'd1, 5'b11111, 4'd15, "blink");
        repeat (24) cycle(2'd2, 5'b00001, 4'd15, "rotate");
        repeat (6)  cycle(2'd2, 5'($urandom), 4'd15, "rotate_patchg");
        repeat (40) cycle(2'd3, 5'b00000, 4'd15, "bounce");
        repeat (3)  cycle(2'd0, 5'b00000, 4'd15, "bounce_exit");
        cycle(2'd3, 5'b00000, 4'd15, "bounce_restart");
        check("bounce_restart_pos0", 32'(led), 32'(5'b00001));
        repeat (12) cycle(2'd3, 5'b00000, 4'd15, "bounce2");
        repeat (10) cycle(2'd2, 5'b00000, 4'd15, "rotate_zero");
        repeat (10) cycle(2'd1, 5'($urandom), 4'd15, "blink_patchg");

        // Reset mid-rotation, then reload on release.
        cycle(2'd0, 5'b00000, 4'd15, "pre_rot");
        cycle(2'd2, 5'b00001, 4'd15, "rot_rst");
        repeat (8) cycle(2'd2, 5'b00001, 4'd15, "rot_rst");
        check("rot_before_rst", 32'(led), 32'(5'b00100));
        pulse_reset("rot_mid");
        cycle(2'd2, 5'b10010, 4'd15, "rot_reload");
        check("rot_reload_value", 32'(led), 32'(5'b10010));
        repeat (8) cycle(2'd2, 5'b10010, 4'd15, "rot_after");

        repeat (32) cycle(2'd0, 5'b11111, 4'd4, "pwm_duty4");
        repeat (16) cycle(2'd0, 5'b11111, 4'd0, "pwm_duty0");

        repeat (250) begin
            md   = 2'($urandom_range(0, 3));
            pat  = 5'($urandom);
            hold = $urandom_range(1, 14);
            for (int j = 0; j < hold; j++) begin
                if ($urandom_range(0, 3) == 0) pat = 5'($urandom);
                cycle(md, pat, 4'($urandom), "rand");
            end
            if ($urandom_range(0, 24) == 0) pulse_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
